// File: rtl/vector_queue.sv
// vector_queue: 16-deep circular buffer of beam endpoints feeding a line drawer.
// Latency: a write into an empty idle queue strobes out two edges later (strobe high in the cycle after edge E+1).
// Backpressure: pops only while lineto_ready=1 and at most every other cycle; writes while full are dropped and set sticky overflow.
//
// Ports:
//   clk, reset                 - single clock, synchronous active-high reset
//   wr_strobe/wr_x/wr_y/wr_bright - enqueue request and point payload
//   full, empty, count         - occupancy status, decoded from the count register
//   overflow                   - sticky: at least one write was dropped since reset
//   lineto_ready               - downstream line drawer can take a new endpoint
//   lineto_strobe              - one-cycle pulse presenting x_out/y_out/bright_out
//   x_out, y_out, bright_out   - last popped endpoint, held until the next pop
module vector_queue #(
  parameter int BITS       = 12,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_strobe,
  input  logic [BITS-1:0]       wr_x,
  input  logic [BITS-1:0]       wr_y,
  input  logic                  wr_bright,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  lineto_ready,
  output logic                  lineto_strobe,
  output logic [BITS-1:0]       x_out,
  output logic [BITS-1:0]       y_out,
  output logic                  bright_out
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Occupancy value meaning "every slot used"; count is one bit wider than
  // the pointers so that full and empty are distinguishable.
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef struct packed {
    logic            bright;
    logic [BITS-1:0] y;
    logic [BITS-1:0] x;
  } entry_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GUARD = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  entry_t                mem_q [DEPTH];
  entry_t                mem_d [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  state_t                state_q, state_d;
  logic                  strobe_q, strobe_d;
  entry_t                out_q, out_d;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic   full_w;
  logic   empty_w;
  logic   wr_accept;
  logic   wr_drop;
  logic   pop;
  entry_t wr_entry;
  entry_t head_entry;

  // Both status flags come from the registered count, so a write is judged
  // against the pre-edge occupancy even if a pop happens on the same edge,
  // and a freshly written entry cannot be popped in the cycle it arrives.
  assign full_w    = (count_q == FULL_CNT);
  assign empty_w   = (count_q == '0);

  assign wr_accept = wr_strobe && !full_w;
  assign wr_drop   = wr_strobe &&  full_w;

  // GUARD blocks the pop for one cycle after every strobe so a ready that the
  // drawer drops in response to the strobe is never seen stale.
  assign pop       = (state_q == ST_IDLE) && lineto_ready && !empty_w;

  assign wr_entry   = '{bright: wr_bright, y: wr_y, x: wr_x};
  assign head_entry = mem_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Storage and pointers
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_d = mem_q;
    if (wr_accept) begin
      mem_d[wr_ptr_q] = wr_entry;
    end
  end

  always_comb begin
    // Pointers are exactly DEPTH_LOG2 bits wide, so +1 wraps modulo DEPTH.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({wr_accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;  // idle, or write and pop cancel out
    endcase
  end

  always_comb begin
    overflow_d = overflow_q || wr_drop;
  end

  // ---------------------------------------------------------------------------
  // Output FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    strobe_d = 1'b0;
    out_d    = out_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pop) begin
          out_d    = head_entry;
          strobe_d = 1'b1;
          state_d  = ST_GUARD;
        end
      end
      ST_GUARD: begin
        // lineto_ready deliberately not looked at here.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // Payload storage carries no reset: stale slots are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
      strobe_q   <= 1'b0;
      out_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      strobe_q   <= strobe_d;
      out_q      <= out_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign full          = full_w;
  assign empty         = empty_w;
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign lineto_strobe = strobe_q;
  assign x_out         = out_q.x;
  assign y_out         = out_q.y;
  assign bright_out    = out_q.bright;

endmodule

// File: tb/tb_vector_queue.sv
module tb_vector_queue;

  logic        clk;
  logic        reset;
  logic        wr_strobe;
  logic [11:0] wr_x;
  logic [11:0] wr_y;
  logic        wr_bright;
  logic        full;
  logic        empty;
  logic [4:0]  count;
  logic        overflow;
  logic        lineto_ready;
  logic        lineto_strobe;
  logic [11:0] x_out;
  logic [11:0] y_out;
  logic        bright_out;

  vector_queue #(.BITS(12), .DEPTH_LOG2(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_strobe     (wr_strobe),
    .wr_x          (wr_x),
    .wr_y          (wr_y),
    .wr_bright     (wr_bright),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .overflow      (overflow),
    .lineto_ready  (lineto_ready),
    .lineto_strobe (lineto_strobe),
    .x_out         (x_out),
    .y_out         (y_out),
    .bright_out    (bright_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain queue of points plus the observable output state.
  typedef struct packed {
    logic        b;
    logic [11:0] y;
    logic [11:0] x;
  } ent_t;

  ent_t        mq[$];
  logic        m_ovf = 1'b0;
  logic        m_stb = 1'b0;
  logic [11:0] m_x = '0;
  logic [11:0] m_y = '0;
  logic        m_b = 1'b0;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge using the inputs currently applied, clock
  // the DUT, then compare every output at the falling edge.
  task automatic cycle();
    logic do_pop;
    logic was_full;
    ent_t e;
    if (reset) begin
      mq.delete();
      m_ovf = 1'b0;
      m_stb = 1'b0;
      m_x = '0;
      m_y = '0;
      m_b = 1'b0;
    end else begin
      // A pop needs ready, a non-empty queue, and no strobe in the current cycle.
      do_pop   = !m_stb && lineto_ready && (mq.size() != 0);
      was_full = (mq.size() == 16);
      if (wr_strobe && was_full) m_ovf = 1'b1;
      if (do_pop) begin
        e   = mq.pop_front();
        m_x = e.x;
        m_y = e.y;
        m_b = e.b;
      end
      m_stb = do_pop;
      if (wr_strobe && !was_full) mq.push_back('{b: wr_bright, y: wr_y, x: wr_x});
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("strobe", lineto_strobe, m_stb);
    chk("count", count, mq.size());
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == 16);
    chk("overflow", overflow, m_ovf);
    chk("x_out", x_out, m_x);
    chk("y_out", y_out, m_y);
    chk("bright_out", bright_out, m_b);
  endtask

  task automatic wr1(input logic [11:0] x, input logic [11:0] y, input logic b);
    wr_x = x;
    wr_y = y;
    wr_bright = b;
    wr_strobe = 1'b1;
    cycle();
    wr_strobe = 1'b0;
  endtask

  initial begin
    int idx;
    int prev;
    int nw;
    int maxc;
    reset = 1'b1;
    wr_strobe = 1'b0;
    wr_x = '0;
    wr_y = '0;
    wr_bright = 1'b0;
    lineto_ready = 1'b0;

    // Reset state
    cycle();
    cycle();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    reset = 1'b0;

    // Basic: single point, strobe two edges after the write
    lineto_ready = 1'b1;
    wr1(12'h123, 12'h456, 1'b1);
    chk("basic_no_early_stb", lineto_strobe, 0);
    cycle();
    chk("basic_stb", lineto_strobe, 1);
    chk("basic_x", x_out, 12'h123);
    chk("basic_y", y_out, 12'h456);
    chk("basic_b", bright_out, 1);
    cycle();
    chk("basic_stb_low", lineto_strobe, 0);
    chk("basic_empty", empty, 1);

    // Fill to 16, overflow on the 17th, then drain in order
    lineto_ready = 1'b0;
    for (int i = 0; i < 16; i++) wr1(12'(i), 12'(15 - i), i[0]);
    chk("fill_count", count, 16);
    chk("fill_full", full, 1);
    wr1(12'h7ff, 12'h7ff, 1'b1);
    chk("fill_ovf", overflow, 1);
    chk("fill_count_hold", count, 16);
    lineto_ready = 1'b1;
    idx = 0;
    prev = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (lineto_strobe) begin
        chk("fill_order_x", x_out, idx);
        chk("fill_order_y", y_out, 15 - idx);
        if (idx > 0) chk("fill_spacing", cyc - prev, 2);
        prev = cyc;
        idx++;
      end
    end
    chk("fill_n_strobes", idx, 16);
    chk("fill_ovf_sticky", overflow, 1);

    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst_ovf_clear", overflow, 0);

    // Simultaneous write and pop
    lineto_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr1(12'(16'h100 + i), 12'(i), 1'b0);
    lineto_ready = 1'b1;
    wr1(12'h0aa, 12'h0bb, 1'b1);
    lineto_ready = 1'b0;
    chk("sim_count3", count, 3);
    chk("sim_stb", lineto_strobe, 1);
    cycle();
    for (int i = 0; i < 13; i++) wr1(12'($urandom), 12'($urandom), 1'($urandom));
    chk("sim_full", full, 1);
    lineto_ready = 1'b1;
    wr1(12'hfff, 12'hfff, 1'b1);
    lineto_ready = 1'b0;
    chk("sim_drop_count", count, 15);
    chk("sim_drop_ovf", overflow, 1);
    chk("sim_drop_stb", lineto_strobe, 1);

    reset = 1'b1;
    cycle();
    reset = 1'b0;

    // Backpressure: outputs hold while ready is low
    lineto_ready = 1'b1;
    wr1(12'habc, 12'h321, 1'b1);
    cycle();
    cycle();
    lineto_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr1(12'(i + 1), 12'(i + 2), 1'b0);
    for (int i = 0; i < 50; i++) begin
      cycle();
      chk("bp_no_stb", lineto_strobe, 0);
    end
    chk("bp_hold_x", x_out, 12'habc);
    chk("bp_hold_y", y_out, 12'h321);
    chk("bp_hold_b", bright_out, 1);
    chk("bp_count", count, 5);
    lineto_ready = 1'b1;
    idx = 0;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (lineto_strobe) idx++;
    end
    chk("bp_resume_n", idx, 5);

    reset = 1'b1;
    cycle();
    reset = 1'b0;

    // Wrap: 40 random writes interleaved with random ready
    nw = 0;
    maxc = 0;
    for (int i = 0; i < 600 && nw < 40; i++) begin
      wr_x = 12'($urandom);
      wr_y = 12'($urandom);
      wr_bright = 1'($urandom);
      wr_strobe = ($urandom_range(0, 2) == 0) && (mq.size() < 16);
      lineto_ready = ($urandom_range(0, 3) != 0);
      if (wr_strobe) nw++;
      cycle();
      if (int'(count) > maxc) maxc = int'(count);
    end
    wr_strobe = 1'b0;
    chk("wrap_n_writes", nw, 40);
    lineto_ready = 1'b1;
    for (int i = 0; i < 40; i++) cycle();
    chk("wrap_empty", empty, 1);
    chk("wrap_ovf", overflow, 0);
    chk("wrap_max_le16", maxc <= 16, 1);

    // Reset while in GUARD with 4 entries left
    lineto_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr1(12'(12'h200 + i), 12'(12'h300 + i), 1'b1);
    lineto_ready = 1'b1;
    cycle();
    lineto_ready = 1'b0;
    chk("guard_stb", lineto_strobe, 1);
    chk("guard_count", count, 4);
    reset = 1'b1;
    wr_x = 12'h555;
    wr_y = 12'h666;
    wr_bright = 1'b1;
    wr_strobe = 1'b1;
    lineto_ready = 1'b1;
    cycle();
    wr_strobe = 1'b0;
    reset = 1'b0;
    chk("grst_stb", lineto_strobe, 0);
    chk("grst_count", count, 0);
    chk("grst_empty", empty, 1);
    chk("grst_ovf", overflow, 0);
    chk("grst_x", x_out, 0);
    chk("grst_y", y_out, 0);
    chk("grst_b", bright_out, 0);
    cycle();
    cycle();
    chk("grst_no_stb_after", lineto_strobe, 0);
    chk("grst_still_empty", empty, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/vector_queue.md
VECTOR_QUEUE -- requirements
Module: vector_queue

Interface
REQ-001 Parameter BITS, default 12, width of each coordinate.
REQ-002 Parameter DEPTH_LOG2, default 4, log2 of queue depth (DEPTH = 16 entries).
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr_strobe  input  1  one-cycle request to enqueue a point.
REQ-006 wr_x  input  BITS  X coordinate to enqueue.
REQ-007 wr_y  input  BITS  Y coordinate to enqueue.
REQ-008 wr_bright  input  1  beam-on flag to enqueue (0 = blanked move).
REQ-009 full  output  1  queue holds DEPTH entries.
REQ-010 empty  output  1  queue holds 0 entries.
REQ-011 count  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
REQ-012 overflow  output  1  sticky flag; a write was dropped.
REQ-013 lineto_ready  input  1  downstream line drawer idle and able to accept a new endpoint.
REQ-014 lineto_strobe  output  1  one-cycle pulse presenting a new endpoint downstream.
REQ-015 x_out  output  BITS  endpoint X, valid while lineto_strobe is high and held afterwards.
REQ-016 y_out  output  BITS  endpoint Y, same timing as x_out.
REQ-017 bright_out  output  1  beam-on flag for the current endpoint, same timing as x_out.

Function
REQ-018 Storage SHALL be a circular buffer of DEPTH entries of {wr_bright, wr_y, wr_x} with DEPTH_LOG2-bit read and write pointers that wrap modulo DEPTH.
REQ-019 Write: if wr_strobe=1 and full=0 at a posedge, the entry SHALL be stored at the write pointer, the write pointer SHALL increment, and count SHALL increment, unless a pop occurs the same cycle.
REQ-020 Write with full=1 SHALL be dropped, leave pointers and count unchanged, and set overflow=1; full is evaluated on pre-edge count, so a write SHALL be dropped even if a pop happens the same cycle.
REQ-021 overflow SHALL remain 1 until reset.
REQ-022 full SHALL equal (count == DEPTH) and empty SHALL equal (count == 0), both combinational from the count register.
REQ-023 Output FSM states: IDLE and GUARD.
REQ-024 IDLE: if lineto_ready=1 and empty=0, at the posedge the FSM SHALL load x_out/y_out/bright_out from the head entry, set lineto_strobe=1, increment the read pointer (a pop), and go to GUARD; otherwise it SHALL stay in IDLE with lineto_strobe=0.
REQ-025 GUARD: at the next posedge the FSM SHALL clear lineto_strobe and return to IDLE, ignoring lineto_ready, so the downstream ready drop is never sampled stale.
REQ-026 lineto_strobe SHALL be high for exactly one cycle per popped entry; minimum strobe spacing SHALL be 2 cycles (cycle N+1, N+3, ...).
REQ-027 Latency: write at edge E into an empty queue with FSM in IDLE and lineto_ready=1 SHALL produce lineto_strobe high during the cycle after edge E+1.
REQ-028 Simultaneous accepted write and pop SHALL leave count unchanged; a write into an empty queue SHALL NOT be popped in the same cycle.
REQ-029 x_out/y_out/bright_out SHALL hold their last popped value until the next pop.
REQ-030 Entries SHALL be popped in strict FIFO order, including across pointer wrap-around.

Reset
REQ-031 On reset=1 at a posedge: pointers=0, count=0, empty=1, full=0, overflow=0, lineto_strobe=0, x_out=0, y_out=0, bright_out=0, FSM=IDLE.
REQ-032 Reset mid-operation (including in GUARD) SHALL discard all queued entries; no strobe SHALL be issued in the cycle after reset, and wr_strobe during reset SHALL be ignored.

Verification
REQ-033 Basic: lineto_ready=1, write (x=0x123,y=0x456,bright=1) -> one lineto_strobe pulse two cycles later with x_out=0x123, y_out=0x456, bright_out=1; empty returns to 1.
REQ-034 Fill: lineto_ready=0, 16 writes of x=i, y=15-i -> count=16, full=1; 17th write -> overflow=1, count stays 16; raise ready -> 16 strobes in order x=0..15, spaced 2 cycles.
REQ-035 Wrap: interleave 40 writes and pops with ready toggling randomly -> output sequence equals input sequence, count never exceeds 16, overflow stays 0.
REQ-036 Simultaneous: count=3, write on the same cycle as a pop -> count stays 3; with full=1, write on the pop cycle -> dropped, overflow=1, count=15.
REQ-037 Backpressure: lineto_ready held 0 for 50 cycles with 5 entries queued -> no strobe, outputs hold last value; ready=1 -> strobes resume.
REQ-038 Reset: assert reset in GUARD with 4 entries queued -> next cycle lineto_strobe=0, count=0, empty=1, overflow=0, all outputs 0.
